// File: rtl/fft_ram_arbiter_if.sv
// rtl/fft_ram_arbiter_if.sv - requester-side bus of the FFT sample RAM arbiter
interface fft_ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [2:0]        req;
  logic [2:0]        lock;
  logic [2:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] wdata2;
  logic [2:0]        gnt;
  logic [DATA_W-1:0] rdata;
  logic [2:0]        rvalid;

  modport master (
    output req, lock, we, addr0, addr1, addr2, wdata0, wdata1, wdata2,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, lock, we, addr0, addr1, addr2, wdata0, wdata1, wdata2,
    output gnt, rdata, rvalid
  );
endinterface

// File: rtl/fft_ram_arbiter.sv
// rtl/fft_ram_arbiter.sv - round-robin arbiter with locked bursts for a shared single-port sample RAM
module fft_ram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 1024,
  parameter int LOCK_MAX = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  fft_ram_arbiter_if.slave  bus,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o,
  output logic              oob_err_o
);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        rvalid_q;
  logic              oob_q;
  logic [ADDR_W-1:0] addr_sh_q;
  logic [DATA_W-1:0] wdata_sh_q;

  logic              win_vld;
  logic [1:0]        win_idx;
  logic [1:0]        cand;
  logic              g_vld;
  logic [1:0]        g_idx;
  logic [2:0]        gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              in_range;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Round-robin search: first requester at or after rr_ptr, wrapping 2 -> 0.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_ptr_q;
    cand    = rr_ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
      cand = inc3(cand);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 2'd0;
      cnt_q    <= '0;
      rr_ptr_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // cnt_q holds the number of grants the current burst has already received.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          if (bus.lock[win_idx]) begin
            state_d = BURST;
            owner_d = win_idx;
            cnt_d   = CNT_W'(1);
          end else begin
            rr_ptr_d = inc3(win_idx);
          end
        end
      end
      BURST: begin
        if (bus.req[owner_q] && bus.lock[owner_q] && (cnt_q < CNT_W'(LOCK_MAX - 1))) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = IDLE;
          rr_ptr_d = inc3(owner_q);
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    g_vld = 1'b0;
    g_idx = win_idx;
    case (state_q)
      IDLE: begin
        g_vld = win_vld;
        g_idx = win_idx;
      end
      BURST: begin
        g_vld = bus.req[owner_q];
        g_idx = owner_q;
      end
      default: g_vld = 1'b0;
    endcase
    if (!rst_n) begin
      g_vld = 1'b0;
    end
    gnt = g_vld ? (3'b001 << g_idx) : 3'b000;
  end

  always_comb begin
    case (g_idx)
      2'd0:    begin sel_addr = bus.addr0; sel_wdata = bus.wdata0; end
      2'd1:    begin sel_addr = bus.addr1; sel_wdata = bus.wdata1; end
      default: begin sel_addr = bus.addr2; sel_wdata = bus.wdata2; end
    endcase
    sel_we   = bus.we[g_idx];
    in_range = sel_addr < ADDR_W'(DEPTH);
  end

  // The shadow keeps the RAM address/data stable through idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      rvalid_q   <= 3'b000;
      oob_q      <= 1'b0;
      addr_sh_q  <= '0;
      wdata_sh_q <= '0;
    end else begin
      rvalid_q <= 3'b000;
      if (g_vld) begin
        addr_sh_q  <= sel_addr;
        wdata_sh_q <= sel_wdata;
        if (!in_range) begin
          oob_q <= 1'b1;
        end
        if (!sel_we) begin
          rdata_q  <= in_range ? ram_rdata_i : '0;
          rvalid_q <= gnt;
        end
      end
    end
  end

  assign bus.gnt     = gnt;
  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
  assign ram_we_o    = g_vld && sel_we && in_range;
  assign ram_addr_o  = g_vld ? sel_addr : addr_sh_q;
  assign ram_wdata_o = g_vld ? sel_wdata : wdata_sh_q;
  assign busy_o      = (state_q == BURST);
  assign oob_err_o   = oob_q;
endmodule

// File: tb/tb_fft_ram_arbiter.sv
// tb/tb_fft_ram_arbiter.sv - self-checking bench for fft_ram_arbiter
module tb_fft_ram_arbiter;
  localparam int LOCK_MAX = 4;
  localparam int DEPTH    = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  logic        ram_we;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        busy, oob_err;

  fft_ram_arbiter #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata), .busy_o(busy), .oob_err_o(oob_err)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] seed(input logic [9:0] a);
    return {a, 6'h15} ^ 16'h5a5a;
  endfunction

  logic [15:0] ram [1024];
  bit          written [1024];
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr[9:0]]     <= ram_wdata;
      written[ram_addr[9:0]] <= 1'b1;
    end
  end
  assign ram_rdata = written[ram_addr[9:0]] ? ram[ram_addr[9:0]] : seed(ram_addr[9:0]);

  function automatic logic [15:0] addr_of(input int i);
    case (i)
      0: return bus.addr0;
      1: return bus.addr1;
      default: return bus.addr2;
    endcase
  endfunction

  function automatic logic [15:0] wdata_of(input int i);
    case (i)
      0: return bus.wdata0;
      1: return bus.wdata1;
      default: return bus.wdata2;
    endcase
  endfunction

  // Reference model: burst tracked as owner plus grants taken; memory as written-or-seed.
  bit          m_burst;
  int          m_owner, m_grants, m_ptr, m_g;
  logic [15:0] m_mem [1024];
  bit          m_written [1024];
  logic [15:0] m_rdata, m_ash, m_wsh, m_a, m_wd;
  logic [2:0]  m_rvalid, m_egnt;
  logic        m_oob, m_wr, m_in, m_ewe;

  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      checks++;
      if (bus.gnt !== 3'b000 || ram_we !== 1'b0 || bus.rvalid !== 3'b000 || busy !== 1'b0 ||
          oob_err !== 1'b0 || bus.rdata !== 16'h0 || ram_addr !== 16'h0 || ram_wdata !== 16'h0) begin
        errors++;
        $display("FAIL reset_hold: gnt=%b we=%b rvalid=%b busy=%b oob=%b rdata=%h addr=%h wdata=%h, required all zero",
                 bus.gnt, ram_we, bus.rvalid, busy, oob_err, bus.rdata, ram_addr, ram_wdata);
      end
      m_burst = 0; m_owner = 0; m_grants = 0; m_ptr = 0;
      m_rdata = 16'h0; m_rvalid = 3'b000; m_oob = 1'b0; m_ash = 16'h0; m_wsh = 16'h0;
    end else begin
      checks++;
      if (bus.rvalid !== m_rvalid || bus.rdata !== m_rdata || busy !== m_burst || oob_err !== m_oob) begin
        errors++;
        $display("FAIL model_regs: rvalid=%b rdata=%h busy=%b oob=%b, required rvalid=%b rdata=%h busy=%b oob=%b",
                 bus.rvalid, bus.rdata, busy, oob_err, m_rvalid, m_rdata, m_burst, m_oob);
      end
      m_g = -1;
      if (m_burst) begin
        if (bus.req[m_owner]) m_g = m_owner;
      end else begin
        for (int k = 0; k < 3; k++)
          if (m_g < 0 && bus.req[(m_ptr + k) % 3]) m_g = (m_ptr + k) % 3;
      end
      if (m_g >= 0) begin
        m_a = addr_of(m_g); m_wd = wdata_of(m_g); m_wr = bus.we[m_g];
        m_in = (m_a < DEPTH); m_egnt = 3'(1 << m_g); m_ewe = m_wr && m_in;
      end else begin
        m_a = m_ash; m_wd = m_wsh; m_wr = 1'b0; m_in = 1'b1; m_egnt = 3'b000; m_ewe = 1'b0;
      end
      checks++;
      if (bus.gnt !== m_egnt || ram_we !== m_ewe || ram_addr !== m_a || ram_wdata !== m_wd) begin
        errors++;
        $display("FAIL model_ram: gnt=%b we=%b addr=%h wdata=%h, required gnt=%b we=%b addr=%h wdata=%h",
                 bus.gnt, ram_we, ram_addr, ram_wdata, m_egnt, m_ewe, m_a, m_wd);
      end
      m_rvalid = 3'b000;
      if (m_g >= 0) begin
        m_ash = m_a; m_wsh = m_wd;
        if (!m_in) m_oob = 1'b1;
        if (m_wr) begin
          if (m_in) begin m_mem[m_a[9:0]] = m_wd; m_written[m_a[9:0]] = 1'b1; end
        end else begin
          m_rdata  = !m_in ? 16'h0 : (m_written[m_a[9:0]] ? m_mem[m_a[9:0]] : seed(m_a[9:0]));
          m_rvalid = m_egnt;
        end
        if (m_burst) begin
          m_grants++;
          if (!bus.lock[m_g] || m_grants >= LOCK_MAX) begin m_burst = 0; m_ptr = (m_owner + 1) % 3; end
        end else if (bus.lock[m_g]) begin
          m_burst = 1; m_owner = m_g; m_grants = 1;
        end else begin
          m_ptr = (m_g + 1) % 3;
        end
      end else if (m_burst) begin
        m_burst = 0; m_ptr = (m_owner + 1) % 3;
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w);
    bus.req = r; bus.lock = l; bus.we = w;
  endtask

  task automatic pulse_reset();
    next_cycle(); rst_n = 1'b0; drive(3'b000, 3'b000, 3'b000);
    next_cycle(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(3'b111, 3'b000, 3'b111);
    bus.addr0 = 16'd3; bus.addr1 = 16'd4; bus.addr2 = 16'd5;
    bus.wdata0 = 16'h1111; bus.wdata1 = 16'h2222; bus.wdata2 = 16'h3333;
    rst_n = 1'b0;
    repeat (2) next_cycle();
    #2;
    checks++;
    if (bus.gnt !== 3'b000 || ram_we !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: gnt=%b ram_we=%b, required 000 and 0", bus.gnt, ram_we);
    end
    checks++;
    if (busy !== 1'b0 || oob_err !== 1'b0 || bus.rvalid !== 3'b000 || bus.rdata !== 16'h0 || ram_addr !== 16'h0) begin
      errors++; $display("FAIL reset_regs: busy=%b oob=%b rvalid=%b rdata=%h addr=%h, required zeros",
                         busy, oob_err, bus.rvalid, bus.rdata, ram_addr);
    end
    next_cycle(); drive(3'b000, 3'b000, 3'b000); rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    next_cycle(); bus.addr0 = 16'd5; bus.wdata0 = 16'h1234; drive(3'b001, 3'b000, 3'b001); #2;
    checks++;
    if (bus.gnt !== 3'b001 || ram_we !== 1'b1 || ram_addr !== 16'd5) begin
      errors++; $display("FAIL t1_write: gnt=%b we=%b addr=%h, required 001 1 0005", bus.gnt, ram_we, ram_addr);
    end
    next_cycle(); bus.addr2 = 16'd5; drive(3'b100, 3'b000, 3'b000); #2;
    checks++;
    if (bus.gnt !== 3'b100) begin errors++; $display("FAIL t1_read_gnt: gnt=%b, required 100", bus.gnt); end
    next_cycle(); drive(3'b000, 3'b000, 3'b000); #2;
    checks++;
    if (bus.rdata !== 16'h1234 || bus.rvalid !== 3'b100) begin
      errors++; $display("FAIL t1_rdata: rdata=%h rvalid=%b, required 1234 100", bus.rdata, bus.rvalid);
    end
    next_cycle(); #2;
    checks++;
    if (bus.rvalid !== 3'b000 || bus.rdata !== 16'h1234) begin
      errors++; $display("FAIL t1_strobe: rvalid=%b rdata=%h, required 000 1234", bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [6];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    pulse_reset();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      bus.addr0 = 16'($urandom_range(0, 63)); bus.addr1 = 16'($urandom_range(0, 63));
      bus.addr2 = 16'($urandom_range(0, 63));
      drive(3'b111, 3'b000, 3'b000); #2;
      checks++;
      if (bus.gnt !== exp_g[c]) begin
        errors++; $display("FAIL t2_rr[%0d]: gnt=%b, required %b", c, bus.gnt, exp_g[c]);
      end
    end
    next_cycle(); drive(3'b000, 3'b000, 3'b000);
  endtask

  task automatic test_lock();
    logic [2:0] rq [7], lk [7], eg [7];
    logic       eb [7];
    rq = '{3'b010, 3'b111, 3'b111, 3'b111, 3'b101, 3'b001, 3'b000};
    lk = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    eg = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001, 3'b000};
    eb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    pulse_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) next_cycle();
      drive(rq[c], lk[c], 3'b000); #2;
      checks++;
      if (bus.gnt !== eg[c] || busy !== eb[c]) begin
        errors++; $display("FAIL t3_lock[%0d]: gnt=%b busy=%b, required %b %b", c, bus.gnt, busy, eg[c], eb[c]);
      end
    end
  endtask

  task automatic test_lock_max();
    logic [2:0] rq [8], eg [8];
    logic       eb [8];
    rq = '{3'b010, 3'b011, 3'b011, 3'b011, 3'b011, 3'b010, 3'b010, 3'b010};
    eg = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010, 3'b010, 3'b010};
    eb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    pulse_reset();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      drive(rq[c], 3'b010, 3'b001); #2;
      checks++;
      if (bus.gnt !== eg[c] || busy !== eb[c]) begin
        errors++; $display("FAIL t4_lockmax[%0d]: gnt=%b busy=%b, required %b %b", c, bus.gnt, busy, eg[c], eb[c]);
      end
    end
    next_cycle(); drive(3'b000, 3'b000, 3'b000);
  endtask

  task automatic test_oob();
    pulse_reset();
    bus.addr0 = 16'd5; drive(3'b001, 3'b000, 3'b000);
    next_cycle(); bus.addr0 = 16'd1024; bus.wdata0 = 16'hbeef; drive(3'b001, 3'b000, 3'b001); #2;
    checks++;
    if (bus.rdata !== 16'h1234 || bus.rvalid !== 3'b001 || oob_err !== 1'b0) begin
      errors++; $display("FAIL t5_pre: rdata=%h rvalid=%b oob=%b, required 1234 001 0", bus.rdata, bus.rvalid, oob_err);
    end
    checks++;
    if (bus.gnt !== 3'b001 || ram_we !== 1'b0) begin
      errors++; $display("FAIL t5_wr_supp: gnt=%b ram_we=%b, required 001 0", bus.gnt, ram_we);
    end
    next_cycle(); bus.addr0 = 16'd2000; drive(3'b001, 3'b000, 3'b000); #2;
    checks++;
    if (oob_err !== 1'b1 || bus.gnt !== 3'b001) begin
      errors++; $display("FAIL t5_oob_set: oob=%b gnt=%b, required 1 001", oob_err, bus.gnt);
    end
    next_cycle(); drive(3'b000, 3'b000, 3'b000); #2;
    checks++;
    if (bus.rdata !== 16'h0 || bus.rvalid !== 3'b001) begin
      errors++; $display("FAIL t5_oob_read: rdata=%h rvalid=%b, required 0000 001", bus.rdata, bus.rvalid);
    end
    repeat (3) next_cycle();
    #2;
    checks++;
    if (oob_err !== 1'b1 || written[0] !== 1'b0) begin
      errors++; $display("FAIL t5_sticky: oob=%b ram0_written=%b, required 1 0", oob_err, written[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    pulse_reset();
    bus.addr1 = 16'd7; drive(3'b010, 3'b010, 3'b000); #2;
    checks++;
    if (bus.gnt !== 3'b010) begin errors++; $display("FAIL t6_start: gnt=%b, required 010", bus.gnt); end
    next_cycle(); #2;
    checks++;
    if (busy !== 1'b1 || bus.rvalid !== 3'b010) begin
      errors++; $display("FAIL t6_burst: busy=%b rvalid=%b, required 1 010", busy, bus.rvalid);
    end
    next_cycle(); rst_n = 1'b0; drive(3'b111, 3'b000, 3'b000); #2;
    checks++;
    if (bus.gnt !== 3'b000 || bus.rvalid !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL t6_reset: gnt=%b rvalid=%b busy=%b, required 000 000 0", bus.gnt, bus.rvalid, busy);
    end
    next_cycle(); rst_n = 1'b1; #2;
    checks++;
    if (bus.gnt !== 3'b001) begin errors++; $display("FAIL t6_after: gnt=%b, required 001", bus.gnt); end
    next_cycle(); drive(3'b000, 3'b000, 3'b000);
  endtask

  task automatic test_random();
    logic [2:0] last_g = 3'b000;
    int         n_gnt = 0;
    pulse_reset();
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      for (int i = 0; i < 3; i++) begin
        if (!bus.req[i] || last_g[i]) begin
          logic [15:0] a, d;
          a = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(1024, 4000)) : 16'($urandom_range(0, 63));
          d = 16'($urandom);
          bus.req[i]  = $urandom_range(0, 1) == 1;
          bus.we[i]   = $urandom_range(0, 1) == 1;
          bus.lock[i] = $urandom_range(0, 3) == 0;
          case (i)
            0: begin bus.addr0 = a; bus.wdata0 = d; end
            1: begin bus.addr1 = a; bus.wdata1 = d; end
            default: begin bus.addr2 = a; bus.wdata2 = d; end
          endcase
        end
      end
      #2;
      last_g = bus.gnt;
      if (bus.gnt != 3'b000) n_gnt++;
      checks++;
      if (!$onehot0(bus.gnt)) begin errors++; $display("FAIL rand_onehot[%0d]: gnt=%b, required one-hot or 000", c, bus.gnt); end
    end
    checks++;
    if (n_gnt < 300) begin errors++; $display("FAIL rand_grants: granted cycles=%0d, required >= 300", n_gnt); end
    next_cycle(); drive(3'b000, 3'b000, 3'b000);
  endtask

  initial begin
    drive(3'b000, 3'b000, 3'b000);
    bus.addr0 = 16'h0; bus.addr1 = 16'h0; bus.addr2 = 16'h0;
    bus.wdata0 = 16'h0; bus.wdata1 = 16'h0; bus.wdata2 = 16'h0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock();
    test_lock_max();
    test_oob();
    test_reset_mid_burst();
    test_random();
    repeat (2) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
